mem_port_arbiter: RTL

- Shares one single-port, fixed-latency unified memory between the fetch stage (read-only requester IF) and the memory stage (read/write requester DM) of the 5-stage pipeline.
- Serialises accesses and drives one memory transaction at a time.
- Returns read data and a one-cycle ready pulse to the owning requester.
- Produces per-requester stall signals that feed the pipeline's stallF/stallD freeze logic.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch requester, the data requester, the shared
// memory and the arbiter. The arbiter connects through the slave modport.
// The requester/memory environment connects through the master modport.
interface mem_port_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
);
  // Fetch requester (read-only)
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [XLEN-1:0]       if_rdata;
  logic                  if_ready;
  logic                  if_stall;

  // Data requester (read/write)
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [XLEN-1:0]       dm_wdata;
  logic [XLEN-1:0]       dm_rdata;
  logic                  dm_ready;
  logic                  dm_stall;

  // Single-port fixed-latency memory
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [XLEN-1:0]       mem_wdata;
  logic [XLEN-1:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ready, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ready, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ready, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ready, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency memory between the
// fetch stage (IF, read-only) and the memory stage (DM, read/write).
// One transaction at a time: IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP.
// Optional build macro ARB_ROUND_ROBIN_EN: ties in IDLE go to the requester
// that did not own the previous transaction; without it DM always beats IF.
module mem_port_arbiter #(
  parameter int XLEN        = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy
);

  localparam int CNT_W   = $clog2(MEM_LATENCY + 1);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Slot index doubles as the generate index below: 0 = IF, 1 = DM.
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } owner_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  owner_t                owner_reg, owner_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [XLEN-1:0]       wdata_reg, wdata_next;
  owner_t                grant;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t                last_owner_reg, last_owner_next;

  // Remember who completed last so the next tie goes to the other side
  always_comb begin
    last_owner_next = last_owner_reg;
    if (state_reg == RESP) begin
      last_owner_next = owner_reg;
    end
  end

  // last_owner register; IF after reset so the first tie favours DM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_reg <= OWNER_IF;
    end else begin
      last_owner_reg <= last_owner_next;
    end
  end
`endif

  // Arbitration among the requests visible in this cycle
  always_comb begin
    grant = OWNER_IF;
    if (bus.dm_req && bus.if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_owner_reg == OWNER_IF) begin
        grant = OWNER_DM;
      end else begin
        grant = OWNER_IF;
      end
`else
      // DM holds the older instruction, so it wins a tie
      grant = OWNER_DM;
`endif
    end else if (bus.dm_req) begin
      grant = OWNER_DM;
    end
  end

  // Next-state logic and transaction latching
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          owner_next = grant;
          if (grant == OWNER_DM) begin
            we_next    = bus.dm_we;
            addr_next  = bus.dm_addr;
            wdata_next = bus.dm_wdata;
          end else begin
            // Fetches never write; mem_wdata keeps its last value
            we_next    = 1'b0;
            addr_next  = bus.if_addr;
          end
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = CNT_W'(MEM_LATENCY - 1);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and latched-transaction registers; reset aborts any transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      owner_reg <= OWNER_IF;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  // Memory side: the strobe and write enable exist only in ISSUE; the
  // address/data registers only change when a new transaction is latched,
  // so they hold their last values outside ISSUE.
  assign bus.mem_req   = (state_reg == ISSUE);
  assign bus.mem_we    = (state_reg == ISSUE) && we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign busy          = (state_reg != IDLE);

  // Per-requester response path: ready pulse and read-data holding register
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
    localparam owner_t SLOT = (gi == 0) ? OWNER_IF : OWNER_DM;

    logic            ready;
    logic            capture;
    logic [XLEN-1:0] rdata_reg;

    assign ready   = (state_reg == RESP) && (owner_reg == SLOT);
    // mem_rdata is valid on the last WAIT cycle; writes leave rdata alone
    assign capture = (state_reg == WAIT) && (cnt_reg == '0) && !we_reg
                     && (owner_reg == SLOT);

    // Read-data register, held until the next read by this requester
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata_reg <= '0;
      end else if (capture) begin
        rdata_reg <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_ready = g_req[0].ready;
  assign bus.if_rdata = g_req[0].rdata_reg;
  assign bus.dm_ready = g_req[1].ready;
  assign bus.dm_rdata = g_req[1].rdata_reg;

  // Stalls feed the pipeline freeze logic directly, hence combinational
  assign bus.if_stall = bus.if_req && !bus.if_ready;
  assign bus.dm_stall = bus.dm_req && !bus.dm_ready;

endmodule
